// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the core/debug memory-port arbiter: FSM states and the
// memory-mux source select.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    S_CORE,
    S_WAIT,
    S_DBG,
    S_COOL
  } arb_state_t;

  typedef enum logic {
    ARB_SRC_CORE,
    ARB_SRC_DBG
  } arb_src_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the multicycle core and a debug/loader
// requester, handing the port over only at instruction boundaries.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_BURST  = 16,
  parameter int CORE_QUOTA = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  output logic        core_ena,
  input  logic [31:0] core_mem_addr,
  input  logic [31:0] core_mem_wr_data,
  input  logic        core_mem_wr_ena,
  output logic [31:0] core_mem_rd_data,
  input  logic [31:0] core_insn_count,
  input  logic        dbg_req,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wr_data,
  input  logic        dbg_wr_ena,
  input  logic        dbg_halt,
  output logic        dbg_gnt,
  output logic [31:0] dbg_rd_data,
  output logic        dbg_rd_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr_ena,
  input  logic [31:0] mem_rd_data
);

  localparam int BEATS_W = $clog2(MAX_BURST + 1);
  localparam int QUOTA_W = $clog2(CORE_QUOTA + 1);
  localparam logic [BEATS_W-1:0] BEATS_MAX = BEATS_W'(MAX_BURST);
  localparam logic [QUOTA_W-1:0] QUOTA_MAX = QUOTA_W'(CORE_QUOTA);

  arb_state_t           state, state_next;
  arb_src_t             src;
  logic [BEATS_W-1:0]   beats, beats_next;
  logic [QUOTA_W-1:0]   quota, quota_next;
  logic [31:0]          cnt_q;
  logic                 pending;
  logic                 boundary;
  logic                 gnt;
  logic                 force_dead;

  function automatic logic [BEATS_W-1:0] sat_inc_beats(input logic [BEATS_W-1:0] v);
    return (v == BEATS_MAX) ? v : v + BEATS_W'(1);
  endfunction

  function automatic logic [QUOTA_W-1:0] sat_inc_quota(input logic [QUOTA_W-1:0] v);
    return (v == QUOTA_MAX) ? v : v + QUOTA_W'(1);
  endfunction

  assign pending  = dbg_req | dbg_halt;
  assign boundary = (core_insn_count != cnt_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_CORE;
      beats <= '0;
      quota <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_next;
      beats <= beats_next;
      quota <= quota_next;
      cnt_q <= core_insn_count;
    end
  end

  always_comb begin
    state_next = state;
    beats_next = beats;
    quota_next = quota;
    src        = ARB_SRC_CORE;
    gnt        = 1'b0;
    force_dead = 1'b0;
    case (state)
      S_CORE: begin
        if (pending) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (boundary && pending) begin
          force_dead = 1'b1;
          beats_next = '0;
          state_next = S_DBG;
        end else if (boundary || !pending) begin
          state_next = S_CORE;
        end
      end
      S_DBG: begin
        src = ARB_SRC_DBG;
        gnt = 1'b1;
        if (dbg_req) beats_next = sat_inc_beats(beats);
        // Halt lifts the burst limit and holds the grant even when idle.
        if (!dbg_halt && (!dbg_req || beats_next == BEATS_MAX)) begin
          quota_next = '0;
          state_next = S_COOL;
        end
      end
      S_COOL: begin
        if (boundary) begin
          quota_next = sat_inc_quota(quota);
          if (quota_next == QUOTA_MAX) begin
            if (pending) begin
              force_dead = 1'b1;
              beats_next = '0;
              state_next = S_DBG;
            end else begin
              state_next = S_CORE;
            end
          end
        end
      end
      default: state_next = S_CORE;
    endcase
  end

  // The handover cycle is dead: core stalled and no write from either side.
  assign core_ena     = rst & ena & (src == ARB_SRC_CORE) & ~force_dead;
  assign mem_addr     = (src == ARB_SRC_DBG) ? dbg_addr    : core_mem_addr;
  assign mem_wr_data  = (src == ARB_SRC_DBG) ? dbg_wr_data : core_mem_wr_data;
  assign mem_wr_ena   = rst & ~force_dead &
                        ((src == ARB_SRC_DBG) ? (dbg_req & dbg_wr_ena) : core_mem_wr_ena);
  assign dbg_gnt      = gnt;
  assign dbg_rd_valid = gnt & dbg_req & ~dbg_wr_ena;
  assign dbg_rd_data      = mem_rd_data;
  assign core_mem_rd_data = mem_rd_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a toy core, a memory and an
// ownership-based reference model of the port hand-over rules.
module tb_mem_port_arbiter;

  localparam int MAX_BURST  = 4;
  localparam int CORE_QUOTA = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        core_ena;
  logic [31:0] core_mem_addr, core_mem_wr_data;
  logic        core_mem_wr_ena;
  logic [31:0] core_mem_rd_data;
  logic [31:0] core_insn_count;
  logic        dbg_req;
  logic [31:0] dbg_addr, dbg_wr_data;
  logic        dbg_wr_ena;
  logic        dbg_halt;
  logic        dbg_gnt;
  logic [31:0] dbg_rd_data;
  logic        dbg_rd_valid;
  logic [31:0] mem_addr, mem_wr_data;
  logic        mem_wr_ena;
  logic [31:0] mem_rd_data;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_BURST(MAX_BURST), .CORE_QUOTA(CORE_QUOTA)) dut (
    .clk(clk), .rst(rst), .ena(ena), .core_ena(core_ena),
    .core_mem_addr(core_mem_addr), .core_mem_wr_data(core_mem_wr_data),
    .core_mem_wr_ena(core_mem_wr_ena), .core_mem_rd_data(core_mem_rd_data),
    .core_insn_count(core_insn_count), .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_wr_data(dbg_wr_data), .dbg_wr_ena(dbg_wr_ena), .dbg_halt(dbg_halt),
    .dbg_gnt(dbg_gnt), .dbg_rd_data(dbg_rd_data), .dbg_rd_valid(dbg_rd_valid),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_ena(mem_wr_ena),
    .mem_rd_data(mem_rd_data)
  );

  function automatic logic [31:0] seed_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  // Memory: combinational read, write on the clock edge.
  logic [31:0] mem_arr [0:255];
  logic        mem_ready = 1'b0;
  assign mem_rd_data = mem_arr[mem_addr[9:2]];
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= seed_word(i);
      mem_ready <= 1'b1;
    end else if (mem_wr_ena) begin
      mem_arr[mem_addr[9:2]] <= mem_wr_data;
    end
  end

  // Reference model state: who owns the port and hand-over bookkeeping.
  logic [31:0] model_mem [0:255];
  bit          m_owner_dbg, m_waiting, m_cooling;
  int          m_burst, m_retired;
  logic [31:0] m_prev;

  int          n_vec = 0;
  int          n_err = 0;
  int          insn_left;
  logic        last_core_ena;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner_dbg = 0; m_waiting = 0; m_cooling = 0;
    m_burst = 0; m_retired = 0; m_prev = '0;
  endtask

  task automatic core_advance();
    if (last_core_ena) begin
      insn_left--;
      if (insn_left == 0) begin
        core_insn_count = core_insn_count + 32'd1;
        insn_left = $urandom_range(1, 3);
      end
    end
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_core_ena"}, 32'(core_ena), 32'd0);
    chk({tag, "_gnt"}, 32'(dbg_gnt), 32'd0);
    chk({tag, "_wr"}, 32'(mem_wr_ena), 32'd0);
    chk({tag, "_rdv"}, 32'(dbg_rd_valid), 32'd0);
    chk({tag, "_addr"}, mem_addr, core_mem_addr);
  endtask

  // One clock cycle: inputs are already applied; predict, compare, advance.
  task automatic step();
    logic        pend, bnd, e_ena, e_wr, e_dbg, e_rdv, handoff;
    logic [31:0] e_addr, e_data;
    #1;
    pend    = dbg_req | dbg_halt;
    bnd     = (core_insn_count != m_prev);
    handoff = 0;
    e_dbg   = m_owner_dbg;
    if (m_owner_dbg) begin
      e_ena = 0; e_addr = dbg_addr; e_data = dbg_wr_data; e_wr = dbg_req & dbg_wr_ena;
      if (dbg_req && m_burst < MAX_BURST) m_burst++;
      if (!dbg_halt && (!dbg_req || m_burst == MAX_BURST)) begin
        m_owner_dbg = 0; m_cooling = 1; m_retired = 0;
      end
    end else begin
      e_ena = ena; e_addr = core_mem_addr; e_data = core_mem_wr_data; e_wr = core_mem_wr_ena;
      if (m_cooling) begin
        if (bnd) begin
          m_retired++;
          if (m_retired >= CORE_QUOTA) begin m_cooling = 0; handoff = pend; end
        end
      end else if (m_waiting) begin
        handoff = bnd && pend;
        if (bnd || !pend) m_waiting = 0;
      end else begin
        m_waiting = pend;
      end
      if (handoff) begin
        e_ena = 0; e_wr = 0; m_owner_dbg = 1; m_burst = 0; m_waiting = 0;
      end
    end
    e_rdv = e_dbg & dbg_req & ~dbg_wr_ena;
    chk("core_ena", 32'(core_ena), 32'(e_ena));
    chk("dbg_gnt", 32'(dbg_gnt), 32'(e_dbg));
    chk("mem_wr_ena", 32'(mem_wr_ena), 32'(e_wr));
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wr_data", mem_wr_data, e_data);
    chk("dbg_rd_valid", 32'(dbg_rd_valid), 32'(e_rdv));
    chk("core_rd_data", core_mem_rd_data, model_mem[e_addr[9:2]]);
    if (e_rdv) chk("dbg_rd_data", dbg_rd_data, model_mem[dbg_addr[9:2]]);
    if (e_wr) model_mem[e_addr[9:2]] = e_data;
    m_prev = core_insn_count;
    last_core_ena = core_ena;
    @(negedge clk);
    core_advance();
  endtask

  task automatic rand_inputs(input int req_pct, input int halt_pct);
    ena              = ($urandom_range(0, 99) < 90);
    dbg_req          = ($urandom_range(0, 99) < req_pct);
    dbg_halt         = ($urandom_range(0, 99) < halt_pct);
    dbg_wr_ena       = 1'($urandom_range(0, 1));
    dbg_addr         = {22'h0, 8'($urandom), 2'b00};
    dbg_wr_data      = $urandom;
    core_mem_addr    = {22'h0, 8'($urandom), 2'b00};
    core_mem_wr_data = $urandom;
    core_mem_wr_ena  = 1'($urandom_range(0, 1));
  endtask

  initial begin
    logic [31:0] snap;
    int          k;
    for (int i = 0; i < 256; i++) model_mem[i] = seed_word(i);
    model_reset();
    core_insn_count = '0; insn_left = 1; last_core_ena = 0;
    rst = 1'b0; ena = 1'b1;
    dbg_req = 0; dbg_halt = 0; dbg_wr_ena = 0; dbg_addr = '0; dbg_wr_data = '0;
    core_mem_addr = 32'h40; core_mem_wr_data = 32'h1234; core_mem_wr_ena = 1'b1;

    @(negedge clk); @(negedge clk);
    reset_check("reset");
    rst = 1'b1;
    step();

    repeat (600) begin rand_inputs(40, 3); step(); end

    // Sustained requests exercise the burst limit and the core quota.
    dbg_halt = 0;
    repeat (80) begin
      rand_inputs(100, 0);
      ena = 1'b1;
      step();
    end

    // Count wrap-around across the halt sequence.
    dbg_req = 0;
    core_insn_count = 32'hFFFF_FFFE;
    rand_inputs(0, 0);
    dbg_halt = 1; ena = 1;
    k = 0;
    while (dbg_gnt !== 1'b1 && k < 50) begin step(); k++; end
    chk("halt_grant", 32'(dbg_gnt), 32'd1);
    snap = core_insn_count;
    repeat (100) step();
    chk("halt_count", core_insn_count, snap);
    repeat (20) begin
      rand_inputs(100, 100);
      step();
    end
    chk("halt_nolimit", 32'(dbg_gnt), 32'd1);

    dbg_req = 1; dbg_wr_ena = 1; dbg_addr = 32'h100; dbg_wr_data = 32'hDEAD_BEEF;
    core_mem_wr_ena = 1;
    step();
    dbg_wr_ena = 0;
    #1;
    chk("read_back", dbg_rd_data, 32'hDEAD_BEEF);
    chk("read_valid", 32'(dbg_rd_valid), 32'd1);
    step();

    // Asynchronous reset in the middle of a debug write burst.
    dbg_req = 1; dbg_wr_ena = 1;
    #2;
    rst = 1'b0;
    #1;
    chk("async_gnt", 32'(dbg_gnt), 32'd0);
    chk("async_wr", 32'(mem_wr_ena), 32'd0);
    chk("async_core_ena", 32'(core_ena), 32'd0);
    model_reset();
    @(negedge clk);
    reset_check("midreset");
    dbg_req = 0; dbg_halt = 0; ena = 1;
    rst = 1'b1;
    step();
    chk("restart_gnt", 32'(dbg_gnt), 32'd0);

    repeat (400) begin rand_inputs(35, 4); step(); end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
